dct_reod_frame_arbiter: RTL and testbench

Frame-level round-robin arbiter sharing one DCT pre-FFT reorder datapath (1200-sample input frames) between two upstream symbol sources. It grants whole frames (sop..eop) to one requester at a time and muxes the granted stream into the reorder sink. It also keeps a channel-tag FIFO so the frames leaving the reorder/FFT chain are labelled with their originating channel. It sits between the two per-antenna demapper outputs and the reorder sink port.

---
 rtl/dct_reod_frame_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_dct_reod_frame_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_reod_frame_arbiter.sv
// dct_reod_frame_arbiter
// Shares one DCT pre-FFT reorder datapath between two demapper sources.
// Whole frames (sop..eop) are granted round-robin and muxed combinationally
// into the reorder sink. A small channel-tag FIFO records the grant order so
// frames leaving the reorder/FFT chain can be labelled with their source.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no owner; arbitrate sop requests, drop orphan (non-sop) beats
// GRANT0 | channel 0 owns the sink until its eop beat transfers
// GRANT1 | channel 1 owns the sink until its eop beat transfers

module dct_reod_frame_arbiter #(
    parameter int wDataInOut = 16,
    parameter int FRAME_LEN  = 1200,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s0_valid,
    input  logic                  s0_sop,
    input  logic                  s0_eop,
    input  logic [wDataInOut-1:0] s0_real,
    input  logic [wDataInOut-1:0] s0_imag,
    output logic                  s0_ready,

    input  logic                  s1_valid,
    input  logic                  s1_sop,
    input  logic                  s1_eop,
    input  logic [wDataInOut-1:0] s1_real,
    input  logic [wDataInOut-1:0] s1_imag,
    output logic                  s1_ready,

    output logic                  dn_valid,
    output logic                  dn_sop,
    output logic                  dn_eop,
    output logic [wDataInOut-1:0] dn_real,
    output logic [wDataInOut-1:0] dn_imag,
    input  logic                  dn_ready,

    input  logic                  mon_valid,
    input  logic                  mon_eop,

    output logic                  out_chan,
    output logic                  out_chan_valid,
    output logic                  err_len,
    output logic                  err_orphan,
    output logic                  err_tag
);

    localparam int          PTR_W       = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int          CNT_W       = PTR_W + 1;
    localparam logic [11:0] FRAME_LEN_C = 12'(FRAME_LEN);
    localparam logic [10:0] BEAT_MAX    = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              last_grant_nxt;
    logic [10:0]       beat_cnt;
    logic [10:0]       beat_cnt_nxt;

    logic              req0;
    logic              req1;
    logic              orphan0;
    logic              orphan1;
    logic              ready0_c;
    logic              ready1_c;
    logic              xfer;
    logic              xfer_eop;
    logic              len_bad;

    logic              tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  tag_cnt;
    logic              tag_full;
    logic              tag_empty;
    logic              tag_push;
    logic              tag_pop_req;
    logic              tag_pop;
    logic              push_chan;

    assign req0        = s0_valid & s0_sop;
    assign req1        = s1_valid & s1_sop;

    assign tag_full    = (tag_cnt == CNT_W'(TAG_DEPTH));
    assign tag_empty   = (tag_cnt == '0);
    assign tag_pop_req = mon_valid & mon_eop;
    assign tag_pop     = tag_pop_req & ~tag_empty;

    // Readies are forced low while reset is held so an abandoned frame cannot
    // leak beats through the orphan-drop path.
    assign s0_ready    = ready0_c & rst_n;
    assign s1_ready    = ready1_c & rst_n;

    assign out_chan_valid = ~tag_empty;
    assign out_chan       = tag_empty ? 1'b0 : tag_mem[rd_ptr];

    assign len_bad = xfer_eop & (({1'b0, beat_cnt} + 12'd1) != FRAME_LEN_C);

    // FSM state, round-robin pointer and in-frame beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    // Next-state, arbitration, stream mux and source readies
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        tag_push       = 1'b0;
        push_chan      = 1'b0;
        orphan0        = 1'b0;
        orphan1        = 1'b0;
        ready0_c       = 1'b0;
        ready1_c       = 1'b0;
        xfer           = 1'b0;
        xfer_eop       = 1'b0;
        dn_valid       = 1'b0;
        dn_sop         = 1'b0;
        dn_eop         = 1'b0;
        dn_real        = '0;
        dn_imag        = '0;

        case (state)
            IDLE: begin
                // a beat without sop while nobody owns the sink is dropped
                orphan0  = s0_valid & ~s0_sop;
                orphan1  = s1_valid & ~s1_sop;
                ready0_c = orphan0;
                ready1_c = orphan1;
                if ((req0 | req1) & dn_ready & ~tag_full) begin
                    if (req0 & req1) begin
                        push_chan = ~last_grant;
                    end else begin
                        push_chan = req1;
                    end
                    tag_push       = 1'b1;
                    last_grant_nxt = push_chan;
                    beat_cnt_nxt   = '0;
                    state_nxt      = push_chan ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                dn_valid = s0_valid;
                dn_sop   = s0_sop;
                dn_eop   = s0_eop;
                dn_real  = s0_real;
                dn_imag  = s0_imag;
                ready0_c = dn_ready;
                xfer     = s0_valid & dn_ready;
                xfer_eop = xfer & s0_eop;
            end
            GRANT1: begin
                dn_valid = s1_valid;
                dn_sop   = s1_sop;
                dn_eop   = s1_eop;
                dn_real  = s1_real;
                dn_imag  = s1_imag;
                ready1_c = dn_ready;
                xfer     = s1_valid & dn_ready;
                xfer_eop = xfer & s1_eop;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // a mid-frame sop is just data; the length check at eop flags it
        if (xfer) begin
            beat_cnt_nxt = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + 11'd1;
        end
        if (xfer_eop) begin
            state_nxt = IDLE;
        end
    end

    // Channel-tag FIFO: push on grant, pop on chain-output eop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem[i] <= 1'b0;
            end
        end else begin
            if (tag_push) begin
                tag_mem[wr_ptr] <= push_chan;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (tag_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Registered single-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len    <= 1'b0;
            err_orphan <= 1'b0;
            err_tag    <= 1'b0;
        end else begin
            err_len    <= len_bad;
            err_orphan <= orphan0 | orphan1;
            err_tag    <= tag_pop_req & tag_empty;
        end
    end

endmodule

// File: tb/tb_dct_reod_frame_arbiter.sv
// Testbench for dct_reod_frame_arbiter: directed scenarios plus a randomized
// phase, all checked every cycle against a frame-ownership reference model.

module tb_dct_reod_frame_arbiter;

    localparam int W  = 16;
    localparam int FL = 1200;
    localparam int TD = 4;

    typedef struct packed {
        logic         sop;
        logic         eop;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s0_valid = 1'b0, s0_sop = 1'b0, s0_eop = 1'b0, s0_ready;
    logic [W-1:0] s0_real = '0, s0_imag = '0;
    logic         s1_valid = 1'b0, s1_sop = 1'b0, s1_eop = 1'b0, s1_ready;
    logic [W-1:0] s1_real = '0, s1_imag = '0;
    logic         dn_valid, dn_sop, dn_eop;
    logic [W-1:0] dn_real, dn_imag;
    logic         dn_ready = 1'b0;
    logic         mon_valid = 1'b0, mon_eop = 1'b0;
    logic         out_chan, out_chan_valid, err_len, err_orphan, err_tag;

    dct_reod_frame_arbiter #(.wDataInOut(W), .FRAME_LEN(FL), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_sop(s0_sop), .s0_eop(s0_eop),
        .s0_real(s0_real), .s0_imag(s0_imag), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_sop(s1_sop), .s1_eop(s1_eop),
        .s1_real(s1_real), .s1_imag(s1_imag), .s1_ready(s1_ready),
        .dn_valid(dn_valid), .dn_sop(dn_sop), .dn_eop(dn_eop),
        .dn_real(dn_real), .dn_imag(dn_imag), .dn_ready(dn_ready),
        .mon_valid(mon_valid), .mon_eop(mon_eop),
        .out_chan(out_chan), .out_chan_valid(out_chan_valid),
        .err_len(err_len), .err_orphan(err_orphan), .err_tag(err_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // source queues and stimulus knobs
    beat_t q0[$];
    beat_t q1[$];
    int    vprob    = 100;
    int    rprob    = 100;
    int    mon_prob = 0;
    logic  mon_force = 1'b0;

    // reference model: who owns the sink, RR pointer, tag order, frame length
    int    m_owner = -1;
    int    m_last  = 1;
    int    m_len   = 0;
    bit    m_tags[$];
    logic  p_len = 1'b0, p_orph = 1'b0, p_tag = 1'b0;

    // observed tallies
    int    n_out_beats = 0;
    int    n_dv        = 0;
    int    cnt_err_len = 0, cnt_err_orph = 0, cnt_err_tag = 0;
    int    sop_cyc[$];
    int    sop_ch[$];
    int    eop_cyc[$];
    int    elen_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_frame(input int ch, input int len, input bit mid_sop);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.sop = (i == 0) || (mid_sop && i == 1);
            b.eop = (i == len - 1);
            b.re  = W'($urandom);
            b.im  = W'($urandom);
            if (ch == 0) q0.push_back(b);
            else         q1.push_back(b);
        end
    endtask

    task automatic drive_inputs();
        beat_t b;
        if (q0.size() > 0 && $urandom_range(99) < vprob) begin
            b = q0[0];
            s0_valid = 1'b1; s0_sop = b.sop; s0_eop = b.eop; s0_real = b.re; s0_imag = b.im;
        end else begin
            s0_valid = 1'b0; s0_sop = 1'b0; s0_eop = 1'b0;
            s0_real = W'($urandom); s0_imag = W'($urandom);
        end
        if (q1.size() > 0 && $urandom_range(99) < vprob) begin
            b = q1[0];
            s1_valid = 1'b1; s1_sop = b.sop; s1_eop = b.eop; s1_real = b.re; s1_imag = b.im;
        end else begin
            s1_valid = 1'b0; s1_sop = 1'b0; s1_eop = 1'b0;
            s1_real = W'($urandom); s1_imag = W'($urandom);
        end
        dn_ready = ($urandom_range(99) < rprob);
        if (mon_force) begin
            mon_valid = 1'b1;
            mon_eop   = 1'b1;
        end else begin
            mon_valid = ($urandom_range(999) < mon_prob);
            mon_eop   = mon_valid && ($urandom_range(1) == 1);
        end
    endtask

    task automatic evaluate();
        logic        e_r0, e_r1, e_dv, e_oc, e_ocv;
        logic [33:0] e_dat, o_dat;
        logic        req0, req1, full, pop_req, n_len, n_orph, n_tag, own_v, own_eop;
        int          g;
        if (!rst_n) begin
            chk("rst_outs", 64'({s0_ready, s1_ready, dn_valid, out_chan_valid, err_len, err_orphan, err_tag}), 64'(0));
            m_owner = -1; m_last = 1; m_len = 0; m_tags.delete();
            p_len = 1'b0; p_orph = 1'b0; p_tag = 1'b0;
            return;
        end
        e_r0 = 1'b0; e_r1 = 1'b0; e_dv = 1'b0; e_dat = '0; o_dat = '0;
        if (m_owner < 0) begin
            e_r0 = s0_valid & ~s0_sop;
            e_r1 = s1_valid & ~s1_sop;
        end else if (m_owner == 0) begin
            e_r0 = dn_ready;
            e_dv = s0_valid;
            if (s0_valid) e_dat = {s0_sop, s0_eop, s0_real, s0_imag};
        end else begin
            e_r1 = dn_ready;
            e_dv = s1_valid;
            if (s1_valid) e_dat = {s1_sop, s1_eop, s1_real, s1_imag};
        end
        if (e_dv) o_dat = {dn_sop, dn_eop, dn_real, dn_imag};
        e_ocv = (m_tags.size() > 0);
        e_oc  = e_ocv ? m_tags[0] : 1'b0;
        chk("cycle",
            64'({s0_ready, s1_ready, dn_valid, o_dat, out_chan, out_chan_valid, err_len, err_orphan, err_tag}),
            64'({e_r0, e_r1, e_dv, e_dat, e_oc, e_ocv, p_len, p_orph, p_tag}));

        if (dn_valid) n_dv++;
        if (dn_valid && dn_ready) begin
            n_out_beats++;
            if (dn_sop) begin
                sop_cyc.push_back(cyc);
                sop_ch.push_back(s1_ready ? 1 : 0);
            end
            if (dn_eop) eop_cyc.push_back(cyc);
        end
        if (err_len) begin cnt_err_len++; elen_cyc.push_back(cyc); end
        if (err_orphan) cnt_err_orph++;
        if (err_tag) cnt_err_tag++;

        // model advance across the coming clock edge
        n_len   = 1'b0;
        n_orph  = (m_owner < 0) && ((s0_valid & ~s0_sop) || (s1_valid & ~s1_sop));
        pop_req = mon_valid & mon_eop;
        n_tag   = pop_req && (m_tags.size() == 0);
        full    = (m_tags.size() >= TD);
        if (pop_req && m_tags.size() > 0) void'(m_tags.pop_front());
        if (m_owner < 0) begin
            req0 = s0_valid & s0_sop;
            req1 = s1_valid & s1_sop;
            if (dn_ready && !full && (req0 || req1)) begin
                g = (req0 && req1) ? (1 - m_last) : (req0 ? 0 : 1);
                m_tags.push_back(g[0]);
                m_last  = g;
                m_owner = g;
                m_len   = 0;
            end
        end else begin
            own_v   = (m_owner == 0) ? s0_valid : s1_valid;
            own_eop = (m_owner == 0) ? s0_eop : s1_eop;
            if (own_v && dn_ready) begin
                m_len++;
                if (own_eop) begin
                    n_len   = (m_len != FL);
                    m_owner = -1;
                end
            end
        end
        p_len = n_len; p_orph = n_orph; p_tag = n_tag;

        if (s0_valid && s0_ready && q0.size() > 0) void'(q0.pop_front());
        if (s1_valid && s1_ready && q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        evaluate();
        cyc++;
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        mon_force = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        sop_cyc.delete(); sop_ch.delete(); eop_cyc.delete(); elen_cyc.delete();
    endtask

    task automatic run_until_idle(input string tag, input int limit);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            step();
            n++;
            done = (q0.size() == 0 && q1.size() == 0 && m_owner < 0);
        end
        chk(tag, 64'(done), 64'(1));
    endtask

    initial begin
        int base, base2, n, gap, nbad, tot;
        // T1: single 1200-beat frame from channel 0
        do_reset();
        vprob = 100; rprob = 100; mon_prob = 0;
        base = n_out_beats;
        push_frame(0, FL, 1'b0);
        step();
        chk("t1_rdy_idle", 64'(s0_ready), 64'(0));
        step();
        chk("t1_rdy_grant", 64'(s0_ready), 64'(1));
        run_until_idle("t1_done", 3000);
        step();
        chk("t1_beats", 64'(n_out_beats - base), 64'(FL));
        chk("t1_ochan", 64'({out_chan_valid, out_chan}), 64'(2'b10));
        chk("t1_errs", 64'(cnt_err_len + cnt_err_orph + cnt_err_tag), 64'(0));

        // T2: both sources, three frames each, simultaneous sop
        do_reset();
        clear_logs();
        mon_prob = 2;
        for (int i = 0; i < 3; i++) begin
            push_frame(0, FL, 1'b0);
            push_frame(1, FL, 1'b0);
        end
        run_until_idle("t2_done", 30000);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_order%0d", i), 64'((sop_ch.size() > i) ? sop_ch[i] : 9), 64'(i % 2));
        end
        for (int i = 0; i < 5; i++) begin
            gap = (sop_cyc.size() > i + 1 && eop_cyc.size() > i) ? (sop_cyc[i+1] - eop_cyc[i]) : -1;
            chk($sformatf("t2_gap%0d", i), 64'(gap >= 2), 64'(1));
        end

        // T3: short frame on channel 1, then a good one
        do_reset();
        clear_logs();
        mon_prob = 0;
        base = cnt_err_len;
        push_frame(1, FL - 1, 1'b0);
        push_frame(1, FL, 1'b0);
        run_until_idle("t3_done", 5000);
        repeat (2) step();
        chk("t3_errlen_cnt", 64'(cnt_err_len - base), 64'(1));
        chk("t3_errlen_when", 64'((elen_cyc.size() > 0 && eop_cyc.size() > 0) ? elen_cyc[0] - eop_cyc[0] : -1), 64'(1));
        chk("t3_frames", 64'(sop_cyc.size()), 64'(2));

        // T4: tag FIFO full blocks the fifth grant until one chain-output eop
        do_reset();
        clear_logs();
        base = cnt_err_len;
        for (int i = 0; i < 5; i++) push_frame(0, 20, 1'b0);
        repeat (120) step();
        chk("t4_grants_full", 64'(sop_cyc.size()), 64'(4));
        chk("t4_waiting", 64'(q0.size()), 64'(20));
        mon_force = 1'b1;
        step();
        mon_force = 1'b0;
        chk("t4_rdy_popcyc", 64'(s0_ready), 64'(0));
        step();
        chk("t4_rdy_after_pop", 64'(s0_ready), 64'(0));
        step();
        chk("t4_rdy_granted", 64'(s0_ready), 64'(1));
        run_until_idle("t4_done", 200);
        step();
        chk("t4_errlen_cnt", 64'(cnt_err_len - base), 64'(5));

        // T5: orphan beats while idle, then a pop with empty FIFO
        do_reset();
        base  = cnt_err_orph;
        base2 = n_dv;
        for (int i = 0; i < 3; i++) q0.push_back('{sop: 1'b0, eop: 1'b0, re: W'(i), im: W'(i)});
        repeat (5) step();
        chk("t5_orphans", 64'(cnt_err_orph - base), 64'(3));
        chk("t5_dn_quiet", 64'(n_dv - base2), 64'(0));
        chk("t5_dropped", 64'(q0.size()), 64'(0));
        base = cnt_err_tag;
        mon_force = 1'b1;
        step();
        mon_force = 1'b0;
        step();
        chk("t5_errtag", 64'(cnt_err_tag - base), 64'(1));

        // T6: asynchronous reset at beat 600 of a frame
        do_reset();
        push_frame(0, FL, 1'b0);
        base = n_out_beats;
        n = 0;
        while ((n_out_beats - base) < 600 && n < 2000) begin
            step();
            n++;
        end
        chk("t6_reach600", 64'(n_out_beats - base), 64'(600));
        @(posedge clk);
        #1;
        drive_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_now", 64'({s0_ready, s1_ready, dn_valid, out_chan_valid}), 64'(0));
        @(negedge clk);
        evaluate();
        cyc++;
        q0.delete();
        q1.delete();
        repeat (2) step();
        rst_n = 1'b1;
        clear_logs();
        push_frame(0, 10, 1'b0);
        push_frame(1, 10, 1'b0);
        run_until_idle("t6_done", 200);
        chk("t6_first", 64'((sop_ch.size() > 0) ? sop_ch[0] : 9), 64'(0));

        // T7: randomized frames, gaps, back-pressure and monitor traffic
        do_reset();
        vprob = 80; rprob = 75; mon_prob = 3;
        base = cnt_err_len;
        base2 = n_out_beats;
        nbad = 0;
        tot = 0;
        for (int i = 0; i < 6; i++) begin
            int len, ch;
            bit mid;
            ch = $urandom_range(1);
            case ($urandom_range(3))
                0:       len = FL;
                1:       len = FL - 1;
                2:       len = FL + 1;
                default: len = 1 + $urandom_range(30);
            endcase
            mid = (len > 1) && ($urandom_range(3) == 0);
            if (len != FL) nbad++;
            tot += len;
            push_frame(ch, len, mid);
        end
        run_until_idle("t7_done", 40000);
        repeat (2) step();
        chk("t7_beats", 64'(n_out_beats - base2), 64'(tot));
        chk("t7_errlen_cnt", 64'(cnt_err_len - base), 64'(nbad));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
